xocc_cmd_issuer: RTL and testbench



---
 rtl/xocc_pkg.sv | 20 ++
 rtl/xocc_tag_fifo.sv | 52 +++++
 rtl/xocc_cmd_issuer.sv | 181 ++++++++++++++++++
 tb/tb_xocc_cmd_issuer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xocc_pkg.sv
// Shared constants for the XOCC command issuer: tag geometry and the
// issue/response FSM state encodings.
package xocc_pkg;

    localparam int TAG_WIDTH = 4;
    localparam int TAG_MSB   = 31;
    localparam int TAG_LSB   = 28;

    typedef logic [TAG_WIDTH-1:0] tag_t;

    localparam logic [1:0] I_IDLE  = 2'd0;
    localparam logic [1:0] I_PUSH  = 2'd1;
    localparam logic [1:0] I_STALL = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_POP   = 2'd1;
    localparam logic [1:0] R_CAPT  = 2'd2;
    localparam logic [1:0] R_HOLD  = 2'd3;

endpackage

// File: rtl/xocc_tag_fifo.sv
// In-order FIFO of tags for commands still waiting on a response.
// Head is read combinationally; pointers and count are registered.
module xocc_tag_fifo
    import xocc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  tag_t                     din,
    output tag_t                     head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    tag_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/xocc_cmd_issuer.sv
// Host-side XOCC command master: tags and pushes GEMM commands, pops and
// tag-matches responses. Optional watchdog enabled by XOCC_CMD_TIMEOUT_EN.
module xocc_cmd_issuer
    import xocc_pkg::*;
#(
    parameter int CMD_WORD_WIDTH  = 32,
    parameter int CMD_WORD_NUM    = 3,
    parameter int RSP_WORD_NUM    = 1,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [CMD_WORD_NUM*CMD_WORD_WIDTH-1:0] req_cmd,
    input  logic                                   req_need_rsp,
    input  logic                                   cmd_fifo_full,
    output logic                                   cmd_fifo_wr_en,
    output logic [CMD_WORD_NUM*CMD_WORD_WIDTH-1:0] cmd_fifo_din,
    input  logic                                   rsp_fifo_empty,
    output logic                                   rsp_fifo_rd_en,
    input  logic [RSP_WORD_NUM*CMD_WORD_WIDTH-1:0] rsp_fifo_dout,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [RSP_WORD_NUM*CMD_WORD_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]                   rsp_tag,
    output logic [$clog2(MAX_OUTSTANDING):0]       outstanding,
    output logic                                   spurious_rsp,
    output logic                                   timeout_err,
    input  logic                                   err_clr
);

    localparam int CMD_W = CMD_WORD_NUM * CMD_WORD_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [1:0]       issue_state;
    logic [1:0]       rsp_state;
    logic             active;
    tag_t             tag_cnt;
    logic             need_rsp_q;
    logic [CMD_W-1:0] cmd_q;
    logic [CMD_W-1:0] tagged_cmd;
    logic             accept;
    logic             push;
    logic             pop;
    logic             capture;
    tag_t             head;
    logic [CNT_W-1:0] count;

    // active keeps req_ready low while reset is asserted and for the first edge after it
    assign req_ready      = active && (issue_state == I_IDLE) && (count < MAX_CNT);
    assign accept         = req_valid && req_ready;
    assign cmd_fifo_wr_en = ((issue_state == I_PUSH) || (issue_state == I_STALL)) && !cmd_fifo_full;
    assign cmd_fifo_din   = cmd_q;
    assign push           = cmd_fifo_wr_en && need_rsp_q;
    assign rsp_fifo_rd_en = (rsp_state == R_POP);
    assign capture        = (rsp_state == R_CAPT);
    assign pop            = capture && (count != '0);
    assign rsp_valid      = (rsp_state == R_HOLD);
    assign outstanding    = count;

    always_comb begin
        tagged_cmd = req_cmd;
        tagged_cmd[TAG_MSB:TAG_LSB] = tag_cnt;
    end

    xocc_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (cmd_q[TAG_MSB:TAG_LSB]),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_state <= I_IDLE;
            active      <= 1'b0;
            tag_cnt     <= '0;
            need_rsp_q  <= 1'b0;
            cmd_q       <= '0;
        end else begin
            active <= 1'b1;
            case (issue_state)
                I_IDLE: begin
                    if (accept) begin
                        cmd_q       <= tagged_cmd;
                        need_rsp_q  <= req_need_rsp;
                        issue_state <= I_PUSH;
                        if (req_need_rsp) begin
                            tag_cnt <= tag_cnt + 4'd1;
                        end
                    end
                end
                I_PUSH:  issue_state <= cmd_fifo_full ? I_STALL : I_IDLE;
                I_STALL: begin
                    if (!cmd_fifo_full) begin
                        issue_state <= I_IDLE;
                    end
                end
                default: issue_state <= I_IDLE;
            endcase
        end
    end

    // A response with nothing outstanding is dropped and flagged instead of presented
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_state    <= R_IDLE;
            rsp_data     <= '0;
            rsp_tag      <= '0;
            spurious_rsp <= 1'b0;
        end else begin
            case (rsp_state)
                R_IDLE: begin
                    if (!rsp_fifo_empty) begin
                        rsp_state <= R_POP;
                    end
                end
                R_POP:  rsp_state <= R_CAPT;
                R_CAPT: begin
                    if (count != '0) begin
                        rsp_data  <= rsp_fifo_dout;
                        rsp_tag   <= head;
                        rsp_state <= R_HOLD;
                    end else begin
                        rsp_state <= R_IDLE;
                    end
                end
                R_HOLD: begin
                    if (rsp_ready) begin
                        rsp_state <= R_IDLE;
                    end
                end
                default: rsp_state <= R_IDLE;
            endcase
            if (err_clr) begin
                spurious_rsp <= 1'b0;
            end else if (capture && (count == '0)) begin
                spurious_rsp <= 1'b1;
            end
        end
    end

`ifdef XOCC_CMD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;

    // Counter saturates at the limit so the error re-asserts if cleared while still stuck
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (capture || (count == '0)) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (err_clr) begin
                timeout_err <= 1'b0;
            end else if (wd_cnt == WD_MAX) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_xocc_cmd_issuer.sv
// Self-checking bench for xocc_cmd_issuer: table-driven issue vectors plus
// scoreboarded command/response streams and hand-written corner sequences.
`timescale 1ns/1ps
module tb_xocc_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [95:0] req_cmd = '0;
    logic        req_need_rsp = 1'b0;
    logic        cmd_fifo_full = 1'b0;
    logic        cmd_fifo_wr_en;
    logic [95:0] cmd_fifo_din;
    logic        rsp_fifo_empty = 1'b1;
    logic        rsp_fifo_rd_en;
    logic [31:0] rsp_fifo_dout = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [3:0]  outstanding;
    logic        spurious_rsp;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    xocc_cmd_issuer #(
        .CMD_WORD_WIDTH  (32),
        .CMD_WORD_NUM    (3),
        .RSP_WORD_NUM    (1),
        .MAX_OUTSTANDING (8),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cmd        (req_cmd),
        .req_need_rsp   (req_need_rsp),
        .cmd_fifo_full  (cmd_fifo_full),
        .cmd_fifo_wr_en (cmd_fifo_wr_en),
        .cmd_fifo_din   (cmd_fifo_din),
        .rsp_fifo_empty (rsp_fifo_empty),
        .rsp_fifo_rd_en (rsp_fifo_rd_en),
        .rsp_fifo_dout  (rsp_fifo_dout),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_tag        (rsp_tag),
        .outstanding    (outstanding),
        .spurious_rsp   (spurious_rsp),
        .timeout_err    (timeout_err),
        .err_clr        (err_clr)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } rsp_t;

    typedef struct {
        logic [95:0] cmd;
        logic        need;
        int          full_cycles;
        logic [95:0] exp_din;
        logic [3:0]  exp_out;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [95:0] cmd_sb [$];
    rsp_t        exp_rsp [$];
    logic [3:0]  exp_tags [$];
    logic [31:0] rsp_src [$];
    logic [3:0]  model_tag = '0;
    logic        pop_pend = 1'b0;
    rsp_t        mon_e;
    vec_t        vecs [4];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event seen or bound expired, expected otherwise", name);
    endtask

    // Command FIFO and response-scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            if (cmd_fifo_wr_en) begin
                check("wr_while_full", cmd_fifo_full, 0);
                if (cmd_sb.size() == 0) fail("unexpected_wr");
                else check("cmd_din", cmd_fifo_din, cmd_sb.pop_front());
            end
            if (rsp_fifo_rd_en) begin
                if (rsp_src.size() == 0) fail("rd_on_empty");
                pop_pend = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) fail("unexpected_rsp");
                else begin
                    mon_e = exp_rsp.pop_front();
                    check("rsp_data", rsp_data, mon_e.data);
                    check("rsp_tag", rsp_tag, mon_e.tag);
                end
            end
        end
    end

    // Standard-mode response FIFO: data appears the cycle after rd_en
    always @(posedge clk) begin
        if (pop_pend) begin
            pop_pend = 1'b0;
            #1;
            if (rsp_src.size() > 0) rsp_fifo_dout = rsp_src.pop_front();
            rsp_fifo_empty = (rsp_src.size() == 0);
        end
    end

    task automatic applyStimulus_push_rsp(input logic [31:0] data);
        rsp_t e;
        rsp_src.push_back(data);
        rsp_fifo_empty = 1'b0;
        if (exp_tags.size() > 0) begin
            e.data = data;
            e.tag  = exp_tags.pop_front();
            exp_rsp.push_back(e);
        end
    endtask

    task automatic next_cmd(input logic [95:0] raw, input logic need, output logic [95:0] exp);
        exp = raw;
        exp[31:28] = model_tag;
        if (need) model_tag = model_tag + 4'd1;
    endtask

    task automatic checkOutput_reset_vals();
        check("rst_req_ready", req_ready, 0);
        check("rst_wr_en", cmd_fifo_wr_en, 0);
        check("rst_rd_en", rsp_fifo_rd_en, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_spurious", spurious_rsp, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_din", cmd_fifo_din, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_outstanding", outstanding, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = 1'b0;
        cmd_fifo_full = 1'b0;
        err_clr = 1'b0;
        rsp_ready = 1'b1;
        cmd_sb.delete();
        exp_rsp.delete();
        exp_tags.delete();
        rsp_src.delete();
        rsp_fifo_empty = 1'b1;
        model_tag = '0;
        #1;
        checkOutput_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus_issue(input logic [95:0] cmd, input logic need,
                                       input int full_cycles, input logic [95:0] exp_din);
        bit ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin fail("ready_timeout"); return; end
        req_cmd = cmd;
        req_need_rsp = need;
        req_valid = 1'b1;
        cmd_fifo_full = (full_cycles > 0);
        cmd_sb.push_back(exp_din);
        if (need) exp_tags.push_back(exp_din[31:28]);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < full_cycles; c++) begin
            @(negedge clk);
            check("stall_req_ready", req_ready, 0);
            check("stall_wr_en", cmd_fifo_wr_en, 0);
            @(posedge clk);
        end
        #1 cmd_fifo_full = 1'b0;
        @(negedge clk);
        check("wr_first_free", cmd_fifo_wr_en, 1);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (cmd_sb.size() == 0) begin ok = 1; break; end
        end
        if (!ok) fail("cmd_push_timeout");
    endtask

    task automatic wait_rsp();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (exp_rsp.size() == 0) begin ok = 1; break; end
        end
        if (!ok) fail("rsp_timeout");
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        logic [95:0] d;
        int n;

        vecs[0] = '{96'hAAAA_0000_BBBB_0000_FFFF_1234, 1'b1, 0, 96'hAAAA_0000_BBBB_0000_0FFF_1234, 4'd1};
        vecs[1] = '{96'h0123_4567_89AB_CDEF_7654_3210, 1'b0, 0, 96'h0123_4567_89AB_CDEF_1654_3210, 4'd1};
        vecs[2] = '{96'hDEAD_BEEF_CAFE_F00D_0000_0000, 1'b1, 5, 96'hDEAD_BEEF_CAFE_F00D_1000_0000, 4'd2};
        vecs[3] = '{96'h0000_0000_0000_0000_A000_0001, 1'b1, 0, 96'h0000_0000_0000_0000_2000_0001, 4'd3};

        do_reset();

        for (int i = 0; i < 4; i++) begin
            applyStimulus_issue(vecs[i].cmd, vecs[i].need, vecs[i].full_cycles, vecs[i].exp_din);
            @(negedge clk);
            check("vec_outstanding", outstanding, vecs[i].exp_out);
        end
        for (int i = 0; i < 3; i++) applyStimulus_push_rsp(32'h1000_0000 + i);
        wait_rsp();
        check("vec_drained", outstanding, 0);

        // Single command with exact response latency
        do_reset();
        next_cmd(96'h1234_5678_9ABC_DEF0_FFFF_0001, 1'b1, d);
        applyStimulus_issue(96'h1234_5678_9ABC_DEF0_FFFF_0001, 1'b1, 0, d);
        @(negedge clk);
        check("single_out1", outstanding, 1);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 applyStimulus_push_rsp(32'hA5A5_0001);
        @(negedge clk);
        check("lat_rd_t0", rsp_fifo_rd_en, 0);
        @(negedge clk);
        check("lat_rd_t1", rsp_fifo_rd_en, 1);
        @(negedge clk);
        check("lat_rd_t2", rsp_fifo_rd_en, 0);
        check("lat_valid_t2", rsp_valid, 0);
        @(negedge clk);
        check("lat_valid_t3", rsp_valid, 1);
        check("single_tag", rsp_tag, 0);
        check("single_out0", outstanding, 0);
        @(negedge clk);
        check("hold_valid", rsp_valid, 1);
        check("hold_data", rsp_data, 32'hA5A5_0001);
        check("hold_no_rd", rsp_fifo_rd_en, 0);
        rsp_ready = 1'b1;
        wait_rsp();

        // Fill to MAX_OUTSTANDING, then one response reopens issue
        do_reset();
        for (int i = 0; i < 8; i++) begin
            next_cmd({$urandom(), $urandom(), $urandom()}, 1'b1, d);
            applyStimulus_issue(d, 1'b1, 0, d);
        end
        @(negedge clk);
        check("full_outstanding", outstanding, 8);
        check("full_ready_low", req_ready, 0);
        applyStimulus_push_rsp(32'h0000_0D00);
        wait_rsp();
        check("reopen_ready", req_ready, 1);
        check("reopen_outstanding", outstanding, 7);
        for (int i = 0; i < 7; i++) applyStimulus_push_rsp(32'hB000_0000 + i);
        wait_rsp();
        check("drain_outstanding", outstanding, 0);

        // Tag wrap across 17 in-order round trips
        for (int i = 0; i < 17; i++) begin
            next_cmd({$urandom(), $urandom(), $urandom()}, 1'b1, d);
            applyStimulus_issue(d, 1'b1, 0, d);
            applyStimulus_push_rsp($urandom());
            wait_rsp();
        end
        check("wrap_outstanding", outstanding, 0);

        // Spurious response and err_clr
        applyStimulus_push_rsp(32'hDEAD_0000);
        repeat (8) @(negedge clk);
        check("spurious_set", spurious_rsp, 1);
        check("spurious_popped", rsp_fifo_empty, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("spurious_clr", spurious_rsp, 0);

        next_cmd(96'h0000_0000_0000_0000_0000_0777, 1'b1, d);
        applyStimulus_issue(96'h0000_0000_0000_0000_0000_0777, 1'b1, 0, d);
`ifdef XOCC_CMD_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_rise", timeout_err, 1);
        check("timeout_not_early", (n >= 15), 1);
        err_clr = 1'b1;
        @(negedge clk);
        check("timeout_clr_priority", timeout_err, 0);
        err_clr = 1'b0;
`else
        n = 0;
        repeat (30) @(negedge clk);
        check("timeout_disabled", timeout_err, 0);
`endif

        // Reset asserted while a command is stalled on a full FIFO
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_cmd = 96'h5555_5555_5555_5555_5555_5555;
        req_need_rsp = 1'b1;
        req_valid = 1'b1;
        cmd_fifo_full = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_no_wr", cmd_fifo_wr_en, 0);
        #2 rst = 1'b0;
        #1;
        checkOutput_reset_vals();
        cmd_sb.delete();
        exp_tags.delete();
        exp_rsp.delete();
        @(negedge clk);
        cmd_fifo_full = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_outstanding", outstanding, 0);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_din", cmd_fifo_din, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
